// File: rtl/countdown_timer_display_if.sv
// Control/display bundle of the countdown timer: divider strobes and buttons in,
// multiplexed 7-segment drive and status out.
interface countdown_timer_display_if;
  logic       Tick_1Hz;
  logic       Scan_Clk;
  logic       Start;
  logic       Clear;
  logic [3:0] Digit_En;
  logic [6:0] Segments;
  logic       Alarm;
  logic [1:0] State;

  modport master (
    output Tick_1Hz, Scan_Clk, Start, Clear,
    input  Digit_En, Segments, Alarm, State
  );

  modport slave (
    input  Tick_1Hz, Scan_Clk, Start, Clear,
    output Digit_En, Segments, Alarm, State
  );
endinterface

// File: rtl/countdown_timer_display.sv
// MM:SS countdown timer held as four BCD digits, with a start/pause/done FSM
// and a 4-digit multiplexed active-low 7-segment display driver.
module countdown_timer_display #(
  parameter int PRESET_MIN = 1,
  parameter int PRESET_SEC = 30
) (
  input logic                      Clock,
  input logic                      Reset,
  countdown_timer_display_if.slave tmr
);

  localparam logic [3:0] PRE_MT = 4'(PRESET_MIN / 10);
  localparam logic [3:0] PRE_MO = 4'(PRESET_MIN % 10);
  localparam logic [3:0] PRE_ST = 4'(PRESET_SEC / 10);
  localparam logic [3:0] PRE_SO = 4'(PRESET_SEC % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic       tick_prev, scan_prev;
  logic       tick_pulse, scan_pulse;
  logic [3:0] mt, mo, st, so;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       count_zero, count_one;
  logic       load_preset, do_dec;
  logic [1:0] scan_idx;
  logic [3:0] digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Edge detectors reset high so a strobe already high at release is not a pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tick_prev <= 1'b1;
      scan_prev <= 1'b1;
    end else begin
      tick_prev <= tmr.Tick_1Hz;
      scan_prev <= tmr.Scan_Clk;
    end
  end

  assign tick_pulse = tmr.Tick_1Hz & ~tick_prev;
  assign scan_pulse = tmr.Scan_Clk & ~scan_prev;

  assign count_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
  assign count_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

  // One-second BCD decrement with borrow chain; only used when the count is non-zero.
  always_comb begin
    dec_mt = mt;
    dec_mo = mo;
    dec_st = st;
    dec_so = so;
    if (so != 4'd0) begin
      dec_so = so - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (st != 4'd0) begin
        dec_st = st - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (mo != 4'd0) begin
          dec_mo = mo - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = mt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Clear overrides everything; a tick in RUN is applied even when Start arrives with it.
  always_comb begin
    state_next  = state;
    load_preset = 1'b0;
    do_dec      = 1'b0;
    if (tmr.Clear) begin
      state_next  = IDLE;
      load_preset = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tmr.Start) state_next = count_zero ? DONE : RUN;
        end
        RUN: begin
          if (tick_pulse) begin
            do_dec = 1'b1;
            if (count_one)      state_next = DONE;
            else if (tmr.Start) state_next = PAUSE;
          end else if (tmr.Start) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (tmr.Start) state_next = RUN;
        end
        DONE: begin
          if (tmr.Start) begin
            state_next  = IDLE;
            load_preset = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mt <= PRE_MT;
      mo <= PRE_MO;
      st <= PRE_ST;
      so <= PRE_SO;
    end else if (load_preset) begin
      mt <= PRE_MT;
      mo <= PRE_MO;
      st <= PRE_ST;
      so <= PRE_SO;
    end else if (do_dec) begin
      mt <= dec_mt;
      mo <= dec_mo;
      st <= dec_st;
      so <= dec_so;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)          scan_idx <= 2'd0;
    else if (scan_pulse) scan_idx <= scan_idx + 2'd1;
  end

  // Display mux: index 0 is seconds ones, 3 is minutes tens (blanked when zero).
  always_comb begin
    case (scan_idx)
      2'd0:    digit = so;
      2'd1:    digit = st;
      2'd2:    digit = mo;
      default: digit = mt;
    endcase
    tmr.Digit_En = ~(4'b0001 << scan_idx);
    if ((scan_idx == 2'd3) && (mt == 4'd0)) tmr.Segments = 7'b1111111;
    else                                    tmr.Segments = seg_decode(digit);
  end

  assign tmr.Alarm = (state == DONE);
  assign tmr.State = state;

endmodule

// File: tb/tb_countdown_timer_display.sv
// Drives several differently-preset timers from shared stimulus and compares
// every output against a seconds-based reference model each cycle.
module tb_countdown_timer_display;

  localparam int N = 4;
  localparam int PRE_MIN [N] = '{0, 10, 0, 23};
  localparam int PRE_SEC [N] = '{3, 0, 0, 45};
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0, clear = 1'b0, tick = 1'b0, scan = 1'b0;

  logic [3:0] obs_en    [N];
  logic [6:0] obs_seg   [N];
  logic       obs_alarm [N];
  logic [1:0] obs_state [N];

  int tests  = 0;
  int failed = 0;

  int   m_secs  [N];
  int   m_state [N];
  int   m_idx   [N];
  logic m_ptick, m_pscan;

  always #5 Clock = ~Clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    countdown_timer_display_if tmr();
    assign tmr.Tick_1Hz = tick;
    assign tmr.Scan_Clk = scan;
    assign tmr.Start    = start;
    assign tmr.Clear    = clear;
    assign obs_en[g]    = tmr.Digit_En;
    assign obs_seg[g]   = tmr.Segments;
    assign obs_alarm[g] = tmr.Alarm;
    assign obs_state[g] = tmr.State;

    countdown_timer_display #(
      .PRESET_MIN(PRE_MIN[g]),
      .PRESET_SEC(PRE_SEC[g])
    ) u_dut (
      .Clock(Clock),
      .Reset(Reset),
      .tmr  (tmr)
    );
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int preset_secs(input int i);
    return PRE_MIN[i] * 60 + PRE_SEC[i];
  endfunction

  task automatic model_reset();
    m_ptick = 1'b1;
    m_pscan = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_secs[i]  = preset_secs(i);
      m_state[i] = M_IDLE;
      m_idx[i]   = 0;
    end
  endtask

  task automatic model_step();
    logic tp, sp;
    tp = tick && !m_ptick;
    sp = scan && !m_pscan;
    m_ptick = tick;
    m_pscan = scan;
    for (int i = 0; i < N; i++) begin
      if (sp) m_idx[i] = (m_idx[i] + 1) % 4;
      if (clear) begin
        m_state[i] = M_IDLE;
        m_secs[i]  = preset_secs(i);
      end else begin
        case (m_state[i])
          M_IDLE:  if (start) m_state[i] = (m_secs[i] == 0) ? M_DONE : M_RUN;
          M_RUN: begin
            if (tp) m_secs[i] = m_secs[i] - 1;
            if (tp && m_secs[i] == 0) m_state[i] = M_DONE;
            else if (start)           m_state[i] = M_PAUSE;
          end
          M_PAUSE: if (start) m_state[i] = M_RUN;
          default: if (start) begin
            m_state[i] = M_IDLE;
            m_secs[i]  = preset_secs(i);
          end
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    int d;
    logic [3:0] en;
    logic [6:0] seg;
    for (int i = 0; i < N; i++) begin
      case (m_idx[i])
        0:       d = m_secs[i] % 10;
        1:       d = (m_secs[i] % 60) / 10;
        2:       d = (m_secs[i] / 60) % 10;
        default: d = m_secs[i] / 600;
      endcase
      en  = 4'hf ^ (4'h1 << m_idx[i]);
      seg = (m_idx[i] == 3 && d == 0) ? 7'h7f : SEG[d];
      check_value($sformatf("%s.digit_en[%0d]", tag, i), 32'(obs_en[i]), 32'(en));
      check_value($sformatf("%s.segments[%0d]", tag, i), 32'(obs_seg[i]), 32'(seg));
      check_value($sformatf("%s.alarm[%0d]", tag, i), 32'(obs_alarm[i]), 32'(m_state[i] == M_DONE));
      check_value($sformatf("%s.state[%0d]", tag, i), 32'(obs_state[i]), 32'(m_state[i]));
    end
  endtask

  // Called at a falling edge: drive, advance model over the rising edge, check.
  task automatic cycle(input logic st_i, input logic cl_i, input logic tk_i,
                       input logic sc_i, input logic rn_i);
    start = st_i;
    clear = cl_i;
    tick  = tk_i;
    scan  = sc_i;
    Reset = rn_i;
    if (!rn_i) begin
      model_reset();
      #1 check_all("rst");
    end
    @(posedge Clock);
    if (rn_i) model_step();
    @(negedge Clock);
    check_all("run");
  endtask

  initial begin
    logic st_r, cl_r, tk_r, sc_r, rn_r;
    model_reset();
    @(negedge Clock);

    repeat (3) cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 1);
    cycle(1, 0, 1, 0, 1);
    repeat (3) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 1, 0, 1); end
    repeat (5) begin cycle(0, 0, 0, 1, 1); cycle(0, 0, 0, 0, 1); end
    cycle(1, 0, 0, 0, 1);
    repeat (2) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 1, 0, 1); end
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (2) begin cycle(0, 0, 0, 1, 1); cycle(0, 0, 1, 0, 1); end
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    repeat (2) cycle(0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);

    for (int n = 0; n < 5000; n++) begin
      st_r = !start && ($urandom_range(0, 9) == 0);
      cl_r = !clear && ($urandom_range(0, 79) == 0);
      tk_r = ($urandom_range(0, 2) == 0) ? !tick : tick;
      sc_r = ($urandom_range(0, 1) == 0) ? !scan : scan;
      rn_r = ($urandom_range(0, 499) != 0);
      cycle(st_r, cl_r, tk_r, sc_r, rn_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
